// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: programs a 4-bit serial pattern detector, streams words into it MSB-first and counts matches
module pattern_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              det_ser_in,
  output logic              det_p_load,
  output logic [3:0]        det_pattern,
  output logic              det_o_load,
  output logic              det_overlap,
  input  logic              det_found,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count,
  output logic              count_sat,
  output logic              underrun
);
  localparam int BW = $clog2(WORD_W + 1);
  typedef enum logic [2:0] {IDLE, CONFIG, FLUSH, STREAM, DRAIN, DONE} state_t;
  state_t            state;
  logic [3:0]        pat_q;
  logic              olap_q;
  logic [1:0]        fcnt;
  logic [WORD_W-1:0] sr, hold;
  logic [BW-1:0]     sr_n;
  logic              sr_last, hold_full, hold_last, last_taken, vbit_q;
  logic              f_bit, sr_has, use_hold, data_bit, final_bit, accept;
  logic [CNT_W-1:0]  cnt_inc;
  // The filler bit is the complement of the pattern's newest bit, so it can never complete a match.
  always_comb begin
    f_bit       = ~pat_q[0];
    sr_has      = state == STREAM && sr_n != '0;
    use_hold    = state == STREAM && sr_n == '0 && hold_full;
    data_bit    = sr_has || use_hold;
    final_bit   = sr_has && sr_n == BW'(1) && sr_last;
    word_ready  = (state == FLUSH || state == STREAM) && !last_taken && (!hold_full || use_hold);
    accept      = word_valid && word_ready;
    det_ser_in  = state == IDLE ? 1'b0 : sr_has ? sr[WORD_W-1] : use_hold ? hold[WORD_W-1] : f_bit;
    det_p_load  = state == CONFIG;
    det_o_load  = state == CONFIG;
    det_pattern = state == CONFIG ? pat_q : 4'b0;
    det_overlap = state == CONFIG && olap_q;
    busy        = state != IDLE;
    done        = state == DONE;
    cnt_inc     = match_count + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      olap_q      <= 1'b0;
      fcnt        <= '0;
      sr          <= '0;
      hold        <= '0;
      sr_n        <= '0;
      sr_last     <= 1'b0;
      hold_full   <= 1'b0;
      hold_last   <= 1'b0;
      last_taken  <= 1'b0;
      vbit_q      <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      vbit_q <= data_bit;
      if (vbit_q && det_found && !(&match_count)) begin
        match_count <= cnt_inc;
        if (&cnt_inc) count_sat <= 1'b1;
      end
      if (sr_has) begin
        sr   <= sr << 1;
        sr_n <= sr_n - 1'b1;
      end else if (use_hold) begin
        sr      <= hold << 1;
        sr_n    <= BW'(WORD_W - 1);
        sr_last <= hold_last;
      end else if (state == STREAM) begin
        underrun <= 1'b1;
      end
      if (accept) begin
        hold       <= word_data;
        hold_last  <= word_last;
        hold_full  <= 1'b1;
        last_taken <= word_last;
      end else if (use_hold) begin
        hold_full <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          pat_q       <= cfg_pattern;
          olap_q      <= cfg_overlap;
          match_count <= '0;
          count_sat   <= 1'b0;
          underrun    <= 1'b0;
          hold_full   <= 1'b0;
          last_taken  <= 1'b0;
          sr_n        <= '0;
          state       <= CONFIG;
        end
        CONFIG: begin
          fcnt  <= '0;
          state <= FLUSH;
        end
        FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == 2'd3) state <= STREAM;
        end
        STREAM: if (final_bit) state <= DRAIN;
        DRAIN:  state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
